// File: rtl/dram_port_arb.sv
// Two-master arbiter for the single-port data RAM: CPU (m0) normally wins, the
// UART monitor (m1) wins when the CPU is halted or after STARVE_LIM refusals.
module dram_port_arb #(
    parameter int unsigned ADR_W      = 12,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_run,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADR_W-1:0]  m0_adr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADR_W-1:0]  m1_adr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADR_W-1:0]  ram_adr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIM);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } own_e;

    own_e              rd_own_q, rd_own_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_own_q     <= OWN_NONE;
            starve_cnt_q <= '0;
            adr_q        <= '0;
            wdata_q      <= '0;
        end else begin
            rd_own_q     <= rd_own_d;
            starve_cnt_q <= starve_cnt_d;
            adr_q        <= adr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Grant is same-cycle; forced low while in reset so nothing reaches the RAM.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_n) begin
            if (m0_req && !m1_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req && !m0_req) begin
                m1_gnt = 1'b1;
            end else if (m0_req && m1_req) begin
                if (!cpu_run || (starve_cnt_q >= CNT_LIM)) begin
                    m1_gnt = 1'b1;
                end else begin
                    m0_gnt = 1'b1;
                end
            end
        end
    end

    // RAM command follows the winner; address/data hold their last value when idle.
    always_comb begin
        ram_adr   = adr_q;
        ram_wdata = wdata_q;
        ram_wen   = 1'b0;
        rd_own_d  = OWN_NONE;
        if (m1_gnt) begin
            ram_adr   = m1_adr;
            ram_wdata = m1_wdata;
            ram_wen   = m1_we;
            rd_own_d  = m1_we ? OWN_NONE : OWN_M1;
        end else if (m0_gnt) begin
            ram_adr   = m0_adr;
            ram_wdata = m0_wdata;
            ram_wen   = m0_we;
            rd_own_d  = m0_we ? OWN_NONE : OWN_M0;
        end
        adr_d   = ram_adr;
        wdata_d = ram_wdata;
    end

    always_comb begin
        starve_cnt_d = '0;
        if (m1_req && !m1_gnt) begin
            starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + CNT_W'(1);
        end
    end

    assign m0_rvalid = (rd_own_q == OWN_M0);
    assign m1_rvalid = (rd_own_q == OWN_M1);
    assign m0_rdata  = ram_rdata;
    assign m1_rdata  = ram_rdata;

endmodule
